instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the instruction register.
- Issues byte reads to the byte-organised instruction memory and assembles little-endian 16-bit instructions (low byte at addr, high byte at addr+1).
- Buffers instructions in a small FIFO and presents them to the IR/control path via a valid/ready handshake.
- Supports jump redirect (flush plus new fetch address) and halt (stop issuing fetches).

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 16'h0000, byte fetch address loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  byte read request to instruction memory.
- mem_addr  out  16  byte address of current request.
- mem_ack  in  1  read complete; mem_rdata valid this cycle; sampled only while mem_req=1.
- mem_rdata  in  8  read byte.
- instr_valid  out  1  FIFO head holds an instruction.
- instr  out  16  head instruction {hi_byte, lo_byte}.
- instr_pc  out  16  byte address of the head instruction's low byte.
- instr_ready  in  1  consumer pops head when instr_valid & instr_ready.
- redirect  in  1  jump: flush and refetch from redirect_addr.
- redirect_addr  in  16  new fetch address.
- halt  in  1  no new fetches started while high.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - fpc=RESET_PC, state=IDLE, count=0, mem_req=0, mem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0; FIFO storage cleared.
- FSM states IDLE, FETCH_LO, FETCH_HI:
  - IDLE: mem_req=0, mem_addr=fpc. Go to FETCH_LO when !halt & count<DEPTH.
  - FETCH_LO: mem_req=1, mem_addr=fpc. On mem_ack, latch lo=mem_rdata and go to FETCH_HI.
  - FETCH_HI: mem_req=1, mem_addr=fpc+1 (mod 2^16). On mem_ack, push {mem_rdata, lo} with pc=fpc and set fpc=fpc+2 (mod 2^16).
  - After the push, go to FETCH_LO if !halt & post-update count<DEPTH, else IDLE.
- mem_req/mem_addr are held stable until mem_ack; no cancel is signalled other than mem_req dropping.
- Only one instruction is in flight, and a fetch starts only with count<DEPTH, so a push never overflows.
- Address wrap: fpc=16'hFFFF fetches lo@FFFF, hi@0000; next fpc=0001. Odd addresses are legal.
- FIFO:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Pop when empty is ignored.
- Outputs: instr_valid=(count!=0); instr/instr_pc come combinationally from the head entry and hold their last head value while empty.
- Redirect has top priority after reset; in the cycle it is sampled:
  - count=0; any pop or push that cycle is discarded, including a mem_ack arriving that cycle.
  - fpc=redirect_addr; state=IDLE, so mem_req=0 for at least one cycle.
  - instr_valid=0 from the next cycle.
- Halt does not abort an instruction already in FETCH_LO/FETCH_HI; it completes. FIFO drains normally under halt. Redirect still applies under halt.
- Timing with zero-wait memory (mem_ack tied 1):
  - Reset release at edge 0: FETCH_LO after edge 1, FETCH_HI after edge 2, instr_valid=1 after edge 3.
  - Steady state: one instruction per 2 cycles.
- Reset asserted mid-fetch: immediate return to reset state; the partial lo byte is discarded.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds output perf_flushes[15:0], which counts redirect cycles that discarded ≥1 FIFO entry or an in-flight fetch.
  - Saturates at 16'hFFFF; reset to 0.
- FETCH_PERF_EN undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Memory bytes 00:34,01:12,02:78,03:56; ack tied 1; instr_ready=1 → instr=16'h1234 pc=0000, then 16'h5678 pc=0002; valid 3 cycles after reset release; 2-cycle spacing.
- instr_ready=0, DEPTH=4 → count reaches 4; mem_req=0 and state IDLE; one pop → exactly one new 2-byte fetch, count returns to 4.
- Ack delayed 3 cycles per byte → mem_addr stays 0000 until first ack, then 0001; instr=16'h1234 pushed on second ack only.
- Redirect to 16'h0100 while in FETCH_HI with 2 entries queued, mem_ack=1 that cycle → next cycle count=0, instr_valid=0, mem_req=0; first subsequent instr_pc=0100.
- Redirect to 16'hFFFF; bytes FFFF:CD, 0000:AB → instr=16'hABCD, instr_pc=FFFF; next instr_pc=0001.
- halt=1 asserted during FETCH_LO → that instruction still pushed (count+1); no further mem_req until halt=0; reset=0 mid-FETCH_HI → all outputs return to reset values immediately.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Instruction prefetch stage. Fetches two bytes per instruction
//             from byte-wide instruction memory, assembles little-endian
//             16-bit words and queues them for the IR/control path over a
//             valid/ready handshake. Supports jump redirect and halt.
//  Options  : define FETCH_PERF_EN to add the perf_flushes counter output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         mem_req,
  output logic [15:0]                  mem_addr,
  input  logic                         mem_ack,
  input  logic [7:0]                   mem_rdata,
  output logic                         instr_valid,
  output logic [15:0]                  instr,
  output logic [15:0]                  instr_pc,
  input  logic                         instr_ready,
  input  logic                         redirect,
  input  logic [15:0]                  redirect_addr,
  input  logic                         halt,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]                  perf_flushes
`endif
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH_LO = 2'd1,
    ST_FETCH_HI = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_fpc;
  logic [7:0]           r_lo;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [15:0]          r_fifo_instr [DEPTH];
  logic [15:0]          r_fifo_pc    [DEPTH];
  logic [15:0]          r_last_instr;
  logic [15:0]          r_last_pc;
  logic                 w_push;
  logic                 w_pop;

  // A redirect discards anything completing or leaving in its cycle.
  assign w_push      = (r_state == ST_FETCH_HI) && mem_ack && !redirect;
  assign w_pop       = (r_count != '0) && instr_ready && !redirect;
  assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  // Next-state decode; the refill decision after a push uses post-update occupancy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!halt && (r_count < c_depth)) w_state_nxt = ST_FETCH_LO;
      end
      ST_FETCH_LO: begin
        if (mem_ack) w_state_nxt = ST_FETCH_HI;
      end
      ST_FETCH_HI: begin
        if (mem_ack) begin
          w_state_nxt = (!halt && (w_count_nxt < c_depth)) ? ST_FETCH_LO : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (redirect) w_state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch PC and low-byte holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fpc <= RESET_PC;
      r_lo  <= 8'h00;
    end else if (redirect) begin
      r_fpc <= redirect_addr;
    end else begin
      if ((r_state == ST_FETCH_LO) && mem_ack) r_lo <= mem_rdata;
      if (w_push) r_fpc <= r_fpc + 16'd2;
    end
  end

  // Queue storage, pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= 16'h0000;
        r_fifo_pc[i]    <= 16'h0000;
      end
    end else if (redirect) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_fifo_instr[r_wptr] <= {mem_rdata, r_lo};
        r_fifo_pc[r_wptr]    <= r_fpc;
        r_wptr               <= r_wptr + c_ptr_one;
      end
      if (w_pop) r_rptr <= r_rptr + c_ptr_one;
    end
  end

  // Shadow of the head entry so the outputs hold their last head value while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_instr <= 16'h0000;
      r_last_pc    <= 16'h0000;
    end else if (r_count != '0) begin
      r_last_instr <= r_fifo_instr[r_rptr];
      r_last_pc    <= r_fifo_pc[r_rptr];
    end
  end

  assign mem_req     = (r_state != ST_IDLE);
  assign mem_addr    = (r_state == ST_FETCH_HI) ? (r_fpc + 16'd1) : r_fpc;
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_fifo_instr[r_rptr] : r_last_instr;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rptr]    : r_last_pc;
  assign count       = r_count;

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_flushes;

  // Count redirects that threw away queued or in-flight work; saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_flushes <= 16'h0000;
    end else if (redirect && ((r_count != '0) || (r_state != ST_IDLE)) &&
                 (r_perf_flushes != 16'hFFFF)) begin
      r_perf_flushes <= r_perf_flushes + 16'd1;
    end
  end

  assign perf_flushes = r_perf_flushes;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Directed self-checking bench for instr_fetch_queue (DEPTH=4)
//             with a byte memory model and programmable ack latency.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        halt;
  logic [2:0]  count;

  logic [7:0]  mem [0:65535];
  int          ack_wait;
  int          wcnt;
  int          n_checks;
  int          n_pass;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks after ack_wait idle request cycles, data from mem[].
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= ack_wait) begin
        mem_ack = 1'b1;
        wcnt    = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    mem_rdata = mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 20);
    chk(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    ack_wait = 0; wcnt = 0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_addr = 16'h0000; halt = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h78; mem[16'h0003] = 8'h56;
    mem[16'h0004] = 8'hBC; mem[16'h0005] = 8'h9A;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'hFFFF] = 8'hCD;
    mem[16'h0200] = 8'h44; mem[16'h0201] = 8'h33;

    // Reset state
    tick(); tick();
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_addr",  {16'd0, mem_addr}, 32'h0000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'h0000);
    chk("rst_pc",    {16'd0, instr_pc}, 32'h0000);
    chk("rst_count", {29'd0, count}, 32'd0);

    // Basic fetch, zero-wait memory, consumer always ready
    instr_ready = 1'b1;
    reset = 1'b1;                       // released after edge 0
    tick();                             // edge 1
    chk("e1_req",  {31'd0, mem_req}, 32'd1);
    chk("e1_addr", {16'd0, mem_addr}, 32'h0000);
    tick();                             // edge 2
    chk("e2_addr",  {16'd0, mem_addr}, 32'h0001);
    chk("e2_valid", {31'd0, instr_valid}, 32'd0);
    tick();                             // edge 3
    chk("e3_valid", {31'd0, instr_valid}, 32'd1);
    chk("e3_instr", {16'd0, instr}, 32'h1234);
    chk("e3_pc",    {16'd0, instr_pc}, 32'h0000);
    tick();                             // edge 4: popped, next word in flight
    chk("e4_valid", {31'd0, instr_valid}, 32'd0);
    chk("e4_hold",  {16'd0, instr}, 32'h1234);
    tick();                             // edge 5
    chk("e5_valid", {31'd0, instr_valid}, 32'd1);
    chk("e5_instr", {16'd0, instr}, 32'h5678);
    chk("e5_pc",    {16'd0, instr_pc}, 32'h0002);

    // Fill to DEPTH with consumer stalled
    instr_ready = 1'b0;
    begin
      int n;
      n = 0;
      while (count != 3'd4 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("full_count", {29'd0, count}, 32'd4);
    tick(); tick();
    chk("full_req",  {31'd0, mem_req}, 32'd0);
    chk("full_head", {16'd0, instr}, 32'h5678);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pop_count", {29'd0, count}, 32'd3);
    chk("pop_instr", {16'd0, instr}, 32'h9ABC);
    chk("pop_pc",    {16'd0, instr_pc}, 32'h0004);
    tick();
    chk("refill_req", {31'd0, mem_req}, 32'd1);
    tick(); tick();
    chk("refill_count", {29'd0, count}, 32'd4);
    chk("refill_idle",  {31'd0, mem_req}, 32'd0);
    tick(); tick(); tick();
    chk("one_fetch_req",   {31'd0, mem_req}, 32'd0);
    chk("one_fetch_count", {29'd0, count}, 32'd4);

    // Delayed ack (3 wait cycles per byte) after flushing back to 0000
    ack_wait = 3;
    redirect = 1'b1; redirect_addr = 16'h0000;
    tick();
    redirect = 1'b0;
    chk("flush_count", {29'd0, count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("slow_lo_addr", {15'd0, mem_req, mem_addr}, 32'h1_0000);
    end
    tick();
    chk("slow_hi_addr", {16'd0, mem_addr}, 32'h0001);
    tick(); tick(); tick();
    chk("slow_no_push", {29'd0, count}, 32'd0);
    chk("slow_hi_hold", {16'd0, mem_addr}, 32'h0001);
    tick();
    chk("slow_push",  {29'd0, count}, 32'd1);
    chk("slow_instr", {16'd0, instr}, 32'h1234);

    // Redirect during FETCH_HI with two entries queued and ack that cycle
    ack_wait = 0;
    tick(); tick(); tick();
    chk("pre_rd_count", {29'd0, count}, 32'd2);
    chk("pre_rd_addr",  {16'd0, mem_addr}, 32'h0005);
    redirect = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("rd_count", {29'd0, count}, 32'd0);
    chk("rd_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd_req",   {31'd0, mem_req}, 32'd0);
    instr_ready = 1'b1;
    wait_valid("rd_wait");
    chk("rd_pc",    {16'd0, instr_pc}, 32'h0100);
    chk("rd_instr", {16'd0, instr}, 32'h2211);

    // Address wrap at FFFF
    mem[16'h0000] = 8'hAB;
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    tick();
    redirect = 1'b0;
    wait_valid("wrap_wait");
    chk("wrap_instr", {16'd0, instr}, 32'hABCD);
    chk("wrap_pc",    {16'd0, instr_pc}, 32'hFFFF);
    wait_valid("wrap_wait2");
    chk("wrap_next_pc",    {16'd0, instr_pc}, 32'h0001);
    chk("wrap_next_instr", {16'd0, instr}, 32'h7812);

    // Halt during FETCH_LO lets that instruction finish, then stops fetching
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 16'h0200;
    tick();
    redirect = 1'b0;
    tick();
    chk("halt_lo_addr", {15'd0, mem_req, mem_addr}, 32'h1_0200);
    halt = 1'b1;
    tick(); tick();
    chk("halt_count", {29'd0, count}, 32'd1);
    chk("halt_instr", {16'd0, instr}, 32'h3344);
    chk("halt_req",   {31'd0, mem_req}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("halt_still_req", {31'd0, mem_req}, 32'd0);
    halt = 1'b0;
    tick();
    chk("unhalt_req", {15'd0, mem_req, mem_addr}, 32'h1_0202);
    tick();
    chk("midhi_addr", {15'd0, mem_req, mem_addr}, 32'h1_0203);

    // Asynchronous reset in the middle of FETCH_HI
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req",   {31'd0, mem_req}, 32'd0);
    chk("arst_addr",  {16'd0, mem_addr}, 32'h0000);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", {16'd0, instr}, 32'h0000);
    chk("arst_pc",    {16'd0, instr_pc}, 32'h0000);
    chk("arst_count", {29'd0, count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
